// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
package wrr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority search: first asserted request at or after base, wrapping past N-1.
module rr_pick
  import wrr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[IW'((int'(base) + k) % N)]) begin
        any                                 = 1'b1;
        gnt_idx                             = IW'((int'(base) + k) % N);
        gnt_oh[IW'((int'(base) + k) % N)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Weighted round-robin packet arbiter: grants whole packets, up to weight[i] packets per
// grant, with a registered output stage.
//   state | meaning
//   IDLE  | no owner; pick next requester from ptr_r, load its packet quota
//   GRANT | grant_r owns the output until its quota is spent or it stops at a boundary
module wrr_pkt_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int NUM_INPUTS   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_INPUTS-1:0]             in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0]             in_last,
  output logic [NUM_INPUTS-1:0]             in_ready,
  input  logic [WEIGHT_WIDTH-1:0]           weight [NUM_INPUTS],
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic [idx_width(NUM_INPUTS)-1:0]  out_src,
  input  logic                              out_ready
);

  localparam int IW = idx_width(NUM_INPUTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUTS - 1);
  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_GRANT = GRANT;

  logic [0:0]              state_r;
  logic [IW-1:0]           ptr_r;
  logic [IW-1:0]           grant_r;
  logic [WEIGHT_WIDTH-1:0] quota_r;
  logic                    at_boundary_r;

  logic [NUM_INPUTS-1:0]   pick_oh;
  logic [IW-1:0]           pick_idx;
  logic                    pick_any;
  logic [WEIGHT_WIDTH-1:0] pick_weight;
  logic                    can_take;
  logic                    accept;
  logic                    grant_valid;
  logic                    grant_last;
  logic [IW-1:0]           ptr_next;
  logic [WEIGHT_WIDTH-1:0] quota_dec;

  rr_pick #(.N(NUM_INPUTS), .IW(IW)) u_pick (
    .req     (in_valid),
    .base    (ptr_r),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    pick_weight = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (pick_oh[i]) pick_weight = weight[i];
  end

  assign can_take    = !out_valid || out_ready;
  assign grant_valid = in_valid[grant_r];
  assign grant_last  = in_last[grant_r];
  assign accept      = (state_r == S_GRANT) && can_take && grant_valid;
  assign ptr_next    = (grant_r == LAST_IDX) ? '0 : grant_r + 1'b1;
  assign quota_dec   = quota_r - 1'b1;

  always_comb begin
    in_ready = '0;
    if (state_r == S_GRANT && can_take) in_ready[grant_r] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      ptr_r         <= '0;
      grant_r       <= '0;
      quota_r       <= '0;
      at_boundary_r <= 1'b1;
    end else if (state_r == S_IDLE) begin
      if (pick_any) begin
        grant_r <= pick_idx;
        quota_r <= (pick_weight == '0) ? WEIGHT_WIDTH'(1) : pick_weight;
        state_r <= S_GRANT;
      end
    end else begin
      if (accept) begin
        at_boundary_r <= grant_last;
        if (grant_last) begin
          quota_r <= quota_dec;
          if (quota_dec == '0) begin
            state_r <= S_IDLE;
            ptr_r   <= ptr_next;
          end
        end
      end else if (at_boundary_r && !grant_valid) begin
        // Owner has nothing ready between packets: release rather than hold the output.
        state_r <= S_IDLE;
        ptr_r   <= ptr_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_r];
      out_last  <= grant_last;
      out_src   <= grant_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
